// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    OVERFLOW
  } state_t;

  // Averaging window is 2**AVG_LOG2 measurements.
  localparam int AVG_LOG2 = 2;

endpackage

// File: rtl/module_sync_edge.sv
// Multi-flop synchronizer plus registered rising-edge detector for an
// asynchronous input. edge_pulse is high for one cycle per rising edge.
module module_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain, previous-level flop and registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q     <= sync_q[SYNC_STAGES-1];
      edge_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/module_period_meter.sv
// Period meter: counts clk cycles between rising edges of an asynchronous
// periodic input. Counter saturates at 2**WIDTH-1 and raises ovf_out.
// Optional build macro PERIOD_METER_AVG_EN reports the truncated mean of
// every four measurements instead of each individual measurement.
module module_period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic             valid_out,
  output logic             ovf_out
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state_q;
  state_t           state_nxt;
  logic             edge_pulse;
  logic [WIDTH-1:0] cnt_q;
  logic             sat;
  logic             meas;
  logic             enter_ovf;

  module_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

  assign sat = (cnt_q == CNT_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; an edge coincident with saturation is a measurement.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:     if (edge_pulse) state_nxt = MEASURE;
      MEASURE:  if (!edge_pulse && sat) state_nxt = OVERFLOW;
      OVERFLOW: if (edge_pulse) state_nxt = MEASURE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Action decode: a completed measurement or the entry into overflow.
  always_comb begin
    meas      = 1'b0;
    enter_ovf = 1'b0;
    if (state_q == MEASURE) begin
      meas      = edge_pulse;
      enter_ovf = !edge_pulse && sat;
    end
  end

  // Cycle counter: restarts at 1 on every edge, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (edge_pulse) begin
      cnt_q <= CNT_ONE;
    end else if (state_q == MEASURE && !sat) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Overflow flag: set on entering overflow, cleared by the next measurement.
  always_ff @(posedge clk) begin
    if (rst)            ovf_out <= 1'b0;
    else if (enter_ovf) ovf_out <= 1'b1;
    else if (meas)      ovf_out <= 1'b0;
  end

`ifdef PERIOD_METER_AVG_EN
  localparam int SUM_W = WIDTH + AVG_LOG2;

  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_nxt;
  logic [AVG_LOG2-1:0] idx_q;

  // Truncating divide of the window sum by the window length.
  function automatic logic [WIDTH-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:AVG_LOG2];
  endfunction

  assign sum_nxt = sum_q + SUM_W'(cnt_q);

  // Averager: accumulate four measurements, then publish their mean.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      idx_q      <= '0;
      period_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (enter_ovf) begin
        sum_q <= '0;
        idx_q <= '0;
      end else if (meas) begin
        if (idx_q == '1) begin
          period_out <= avg_trunc(sum_nxt);
          valid_out  <= 1'b1;
          sum_q      <= '0;
          idx_q      <= '0;
        end else begin
          sum_q <= sum_nxt;
          idx_q <= idx_q + AVG_LOG2'(1);
        end
      end
    end
  end
`else
  // Publish every measurement directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= meas;
      if (meas) period_out <= cnt_q;
    end
  end
`endif

endmodule

// File: doc/module_period_meter.md
# module_period_meter

Measures the period of a slow periodic input, such as the `prd_out` tick of `module_divisor`. The period is reported as an integer count of `clk` cycles between consecutive rising edges. This block is the receiving end of the divider's tick: the divider turns a count into a period, and this block turns a period back into a count. It is used on-board for self-checking the divider and for measuring external periodic signals.

## Interface
- `WIDTH`, default 16: width of the cycle counter and of `period_out`. The largest measurable period is 2^WIDTH-1.
- `SYNC_STAGES`, default 2: number of flip-flops in the input synchronizer. Minimum is 2.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sig_in`, in, 1: asynchronous periodic input.
- `period_out`, out, WIDTH: last measured period in `clk` cycles. Held between updates.
- `valid_out`, out, 1: one-cycle pulse in the cycle `period_out` updates.
- `ovf_out`, out, 1: overflow flag. High while no edge has arrived for 2^WIDTH-1 cycles.

## Operation
- **Input path:** `sig_in` passes through the SYNC_STAGES synchronizer. A rising edge is the synchronized level being 1 while its registered previous value is 0.
- **State `IDLE`** (entered on reset): wait for the first edge. On that edge, set `cnt` to 1 and go to `MEASURE`. No `valid_out` is produced for this edge.
- **State `MEASURE`:**
  - On each cycle without an edge, `cnt` increments.
  - On an edge: `period_out` takes `cnt`, `valid_out` pulses, `ovf_out` clears, and `cnt` is set to 1.
  - If `cnt` equals 2^WIDTH-1 and there is no edge, go to `OVERFLOW` and set `ovf_out` to 1. The counter saturates and never wraps.
- **State `OVERFLOW`:**
  - `cnt` holds its value and `ovf_out` stays 1.
  - On an edge, set `cnt` to 1 and go to `MEASURE`, with no `valid_out` (the measured span is unknown).
  - `ovf_out` clears at the next valid measurement.
- **Simultaneous events:**
  - `rst` dominates everything.
  - In `MEASURE`, an edge in the same cycle as the saturation condition counts as a measurement, so period 2^WIDTH-1 is reported and `OVERFLOW` is not entered.
- **Reset mid-period:** the partial count is discarded, all outputs clear, and the state returns to `IDLE`.
- **Minimum reportable period is 2**, meaning the synchronized input must be low for at least one cycle and high for at least one cycle. Pulses shorter than one `clk` cycle may be missed. This is accepted and not flagged.

## Timing
- **Reset values:** `period_out` = 0, `valid_out` = 0, `ovf_out` = 0, state = `IDLE`, `cnt` = 0, synchronizer flops = 0.
- **Latency:** `valid_out` goes high SYNC_STAGES+1 cycles after the first `clk` edge that samples `sig_in` high. This latency is constant, so it does not bias the measured period.
- `period_out` and `valid_out` change in the same cycle.
- **Overflow timing:** `ovf_out` rises exactly 2^WIDTH cycles after the last detected edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **Macro:** `PERIOD_METER_AVG_EN`.
- **Without it:** the block behaves exactly as described above, with one `valid_out` per measurement.
- **With it:**
  - Measurements accumulate into a (WIDTH+2)-bit sum.
  - On every 4th measurement, `period_out` takes sum>>2 (truncated), `valid_out` pulses, and the sum clears.
  - The other three measurements produce no `valid_out`.
  - Entering `OVERFLOW` or reset clears both the sum and the measurement index.

## Structure
- **Package `period_meter_pkg`** contains:
  - `state_t` enum: `IDLE`, `MEASURE`, `OVERFLOW`.
  - `AVG_LOG2` = 2.
- **Sub-module `module_sync_edge`:** the SYNC_STAGES synchronizer plus the rising-edge detector. It outputs a one-cycle `edge_pulse` and is reusable for other asynchronous inputs on the board.
- The top level holds the FSM, the counter, and the optional averager.

## Test plan
1. **Reset:** hold `rst` for 5 cycles, then drive one `sig_in` edge. Required: `period_out` = 0, `valid_out` never pulses, `ovf_out` = 0.
2. **Steady square wave:** 5 cycles high / 5 low. Required: after the second edge, `valid_out` pulses once every 10 cycles with `period_out` = 10.
3. **Period change:** edge spacings of 10, 10, 37, 37. Required: reported periods 10, 10, 37, 37 in order, each with its own single `valid_out` pulse.
4. **Overflow (WIDTH=8):** one edge, then `sig_in` low for 300 cycles. Required: `ovf_out` = 1 exactly 256 cycles after the edge and no `valid_out`. Then drive edges spaced 20 apart. Required: the first edge produces nothing; the second produces `period_out` = 20 with `valid_out`, and `ovf_out` = 0 in that cycle.
5. **Mid-period reset:** assert `rst` 6 cycles into a 10-cycle period. Required: outputs are 0 on the next cycle, and the first 2 edges afterwards yield one `valid_out` with `period_out` = 10.
6. **Averaging (`PERIOD_METER_AVG_EN` defined):** edge spacings of 10, 12, 14, 16. Required: exactly one `valid_out`, with `period_out` = 13.
